dmem_arbiter: RTL

Two-port arbiter placed in front of the data memory so the core load/store unit (port 0) and a secondary master such as DMA or debug (port 1) share a single word-wide, byte-enabled memory port. The block grants at most one access per cycle using round-robin. It drives the memory's address, write-data and byte-enable inputs, and registers the memory's combinational read data into a one-cycle-latency response for the granted port. An optional lock mechanism lets a master keep ownership across a short read-modify-write sequence.

---
 rtl/dmem_arbiter_if.sv | 33 +++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the shared data-memory port of dmem_arbiter.
// The slave modport faces the arbiter. The master modport faces the requesters and the memory.
interface dmem_arb_if;
  logic        req0;
  logic        req1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [3:0]  we0;
  logic [3:0]  we1;
  logic        lock0;
  logic        lock1;
  logic        gnt0;
  logic        gnt1;
  logic        rvalid0;
  logic        rvalid1;
  logic [31:0] rdata;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;

  modport slave (
    input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, lock0, lock1, drdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, daddr, dwdata, dwe
  );

  modport master (
    output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, lock0, lock1, drdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, daddr, dwdata, dwe
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for the data memory, with a registered read response.
// Define DMEM_ARB_LOCK_EN to compile in the FREE/OWN0/OWN1 ownership lock and its cycle counter.
module dmem_arbiter #(
  parameter int unsigned MAX_LOCK = 8
) (
  input logic       clk,
  input logic       reset,
  dmem_arb_if.slave bus
);

  logic        last_q, last_d;
  logic        gnt0, gnt1;
  logic        rd0, rd1;
  logic        rvalid0_q, rvalid1_q;
  logic [31:0] rdata_q, rdata_d;

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {FREE, OWN0, OWN1} state_e;
  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
`else
  logic unused_lock;
  assign unused_lock = bus.lock0 ^ bus.lock1;
`endif

  // last_q = 1 means port 1 was granted most recently, so port 0 wins a tie.
  always_comb begin
    gnt0 = bus.req0 & (~bus.req1 | last_q);
    gnt1 = bus.req1 & (~bus.req0 | ~last_q);
`ifdef DMEM_ARB_LOCK_EN
    if (state_q == OWN0) begin
      gnt0 = bus.req0;
      gnt1 = 1'b0;
    end
    if (state_q == OWN1) begin
      gnt0 = 1'b0;
      gnt1 = bus.req1;
    end
`endif
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign rd0 = gnt0 & (bus.we0 == 4'b0000);
  assign rd1 = gnt1 & (bus.we1 == 4'b0000);

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.daddr   = gnt1 ? bus.addr1  : bus.addr0;
  assign bus.dwdata  = gnt1 ? bus.wdata1 : bus.wdata0;
  assign bus.dwe     = gnt0 ? bus.we0 : (gnt1 ? bus.we1 : 4'b0000);
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata   = rdata_q;

  always_comb begin
    last_d  = last_q;
    rdata_d = rdata_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
    if (rd0 | rd1) begin
      rdata_d = bus.drdata;
    end
`ifdef DMEM_ARB_LOCK_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FREE: begin
        if (gnt0 && bus.lock0) begin
          state_d = OWN0;
          cnt_d   = 8'd1;
        end else if (gnt1 && bus.lock1) begin
          state_d = OWN1;
          cnt_d   = 8'd1;
        end
      end
      OWN0: begin
        // On release the pointer is forced to the owner so the other port wins next.
        if (!bus.lock0 || cnt_q == MAX_CNT) begin
          state_d = FREE;
          cnt_d   = 8'd0;
          last_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      OWN1: begin
        if (!bus.lock1 || cnt_q == MAX_CNT) begin
          state_d = FREE;
          cnt_d   = 8'd0;
          last_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = FREE;
        cnt_d   = 8'd0;
      end
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= 32'h0;
`ifdef DMEM_ARB_LOCK_EN
      state_q   <= FREE;
      cnt_q     <= 8'd0;
`endif
    end else begin
      last_q    <= last_d;
      rvalid0_q <= rd0;
      rvalid1_q <= rd1;
      rdata_q   <= rdata_d;
`ifdef DMEM_ARB_LOCK_EN
      state_q   <= state_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule
